// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
// Shared definitions for the mux scan sequencer: the controller state
// encoding plus the channel, select and dwell-counter widths.
package mux_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int NUM_CH  = 8;
  localparam int SEL_W   = 3;
  localparam int DWELL_W = 4;

endpackage

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Walks the select lines of an external 8:1 mux through channels 0..7,
// samples the mux output once per channel after DWELL extra settle cycles,
// and packs the eight samples into a byte handed downstream over valid/ready.
// Supports single-shot scans and continuous back-to-back scans.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start_i       one-cycle pulse, begins a scan when idle
//   continuous_i  1 = rescan immediately after each word (sampled at start
//                 and again at each word completion)
//   stop_i        pulse, ends continuous mode once the current word completes
//   sel_o[2:0]    registered mux select, sel_o[0] = s0
//   mux_y_i       mux output for the current select
//   data_o[7:0]   captured word, bit k sampled with sel_o == k
//   valid_o       data_o holds a word not yet accepted
//   ready_i       downstream accepts data_o when valid_o && ready_i
//   busy_o        high while scanning
//   overrun_o     sticky, a completed word was dropped; cleared by reset/start
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             continuous_i,
  input  logic             stop_i,
  output logic [SEL_W-1:0] sel_o,
  input  logic             mux_y_i,
  output logic [NUM_CH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL);
  localparam logic [SEL_W-1:0]   LAST_CH    = SEL_W'(NUM_CH - 1);

  scan_state_t         state_q,       state_d;
  logic [SEL_W-1:0]    sel_q,         sel_d;
  logic [DWELL_W-1:0]  dwell_q,       dwell_d;
  logic [NUM_CH-1:0]   shift_q,       shift_d;
  logic [NUM_CH-1:0]   data_q,        data_d;
  logic                valid_q,       valid_d;
  logic                busy_q,        busy_d;
  logic                overrun_q,     overrun_d;
  logic                contLatched_q, contLatched_d;
  logic                stopPending_q, stopPending_d;

  logic [NUM_CH-1:0]   word;
  logic                lastCycle;

  // Next-state logic. The dwell counter counts down from DWELL; the cycle on
  // which it reads zero is the last cycle of the channel, where mux_y_i is
  // captured into the bit addressed by sel and the select advances. The
  // sample from the highest channel completes the word, which either loads
  // into the output register (free slot, or slot being accepted this very
  // cycle) or is dropped and flagged as an overrun. A load always wins over
  // the clear caused by acceptance, so back-to-back handoff keeps valid high.
  // Rescanning needs continuous both latched at start and still asserted at
  // completion, with no stop seen during the word.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    dwell_d       = dwell_q;
    shift_d       = shift_q;
    data_d        = data_q;
    valid_d       = valid_q;
    busy_d        = busy_q;
    overrun_d     = overrun_q;
    contLatched_d = contLatched_q;
    stopPending_d = stopPending_q;

    word          = shift_q;
    word[sel_q]   = mux_y_i;
    lastCycle     = (dwell_q == '0);

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d       = SCAN;
          busy_d        = 1'b1;
          sel_d         = '0;
          dwell_d       = DWELL_LOAD;
          shift_d       = '0;
          overrun_d     = 1'b0;
          contLatched_d = continuous_i;
          stopPending_d = 1'b0;
        end
      end

      SCAN: begin
        if (stop_i) begin
          stopPending_d = 1'b1;
        end

        if (!lastCycle) begin
          dwell_d = dwell_q - 1'b1;
        end else begin
          dwell_d = DWELL_LOAD;
          sel_d   = sel_q + 1'b1;
          shift_d = word;

          if (sel_q == LAST_CH) begin
            shift_d       = '0;
            stopPending_d = 1'b0;

            if (!valid_q || ready_i) begin
              data_d  = word;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end

            if (contLatched_q && continuous_i && !stopPending_q && !stop_i) begin
              contLatched_d = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register. Reset is asynchronous so a scan in progress is abandoned
  // at once and its partial word is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      dwell_q       <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      contLatched_q <= 1'b0;
      stopPending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      dwell_q       <= dwell_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      contLatched_q <= contLatched_d;
      stopPending_q <= stopPending_d;
    end
  end

  assign sel_o     = sel_q;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer
// Self-checking bench for mux_scan_sequencer. Two instances are used: one
// with DWELL=0 (scoreboarded word stream) and one with DWELL=3 (dwell timing).
// Each instance sees a behavioural 8:1 mux built from a bench-held input byte.
module tb_mux_scan_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;

  logic       start0 = 1'b0;
  logic       cont0  = 1'b0;
  logic       stop0  = 1'b0;
  logic       ready0 = 1'b0;
  logic [7:0] in0    = 8'h00;
  logic [2:0] sel0;
  logic [7:0] data0;
  logic       valid0;
  logic       busy0;
  logic       ovr0;
  logic       y0;

  logic       start3 = 1'b0;
  logic       cont3  = 1'b0;
  logic       stop3  = 1'b0;
  logic       ready3 = 1'b0;
  logic [7:0] in3    = 8'h00;
  logic [2:0] sel3;
  logic [7:0] data3;
  logic       valid3;
  logic       busy3;
  logic       ovr3;
  logic       y3;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] expQ[$];
  logic [7:0] expWord;

  always #5 clk = ~clk;

  assign y0 = in0[sel0];
  assign y3 = in3[sel3];

  mux_scan_sequencer #(.DWELL(0)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start0),
    .continuous_i (cont0),
    .stop_i       (stop0),
    .sel_o        (sel0),
    .mux_y_i      (y0),
    .data_o       (data0),
    .valid_o      (valid0),
    .ready_i      (ready0),
    .busy_o       (busy0),
    .overrun_o    (ovr0)
  );

  mux_scan_sequencer #(.DWELL(3)) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start3),
    .continuous_i (cont3),
    .stop_i       (stop3),
    .sel_o        (sel3),
    .mux_y_i      (y3),
    .data_o       (data3),
    .valid_o      (valid3),
    .ready_i      (ready3),
    .busy_o       (busy3),
    .overrun_o    (ovr3)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge; all driving and direct
  // checks happen here, well away from the edge itself.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a mux input byte and pulse start for one cycle. Returns just
  // after the edge that sampled start.
  task automatic applyStimulus(input bit onDwellDut, input logic [7:0] muxWord,
                               input logic contMode);
    tick;
    if (onDwellDut) begin
      in3    = muxWord;
      start3 = 1'b1;
    end else begin
      in0    = muxWord;
      cont0  = contMode;
      start0 = 1'b1;
    end
    tick;
    start0 = 1'b0;
    start3 = 1'b0;
  endtask

  // Scoreboard drain for the DWELL=0 instance: every handshake on the
  // falling edge is followed by acceptance on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && valid0 && ready0) begin
      if (expQ.size() > 0) expWord = expQ.pop_front();
      else                 expWord = 'x;
      checkOutput("sbWord", {24'h0, data0}, {24'h0, expWord});
    end
  end

  initial begin
    #2;
    checkOutput("rstSel",     {29'h0, sel0}, 32'd0);
    checkOutput("rstData",    {24'h0, data0}, 32'd0);
    checkOutput("rstValid",   {31'h0, valid0}, 32'd0);
    checkOutput("rstBusy",    {31'h0, busy0}, 32'd0);
    checkOutput("rstOverrun", {31'h0, ovr0}, 32'd0);
    checkOutput("rstSel3",    {29'h0, sel3}, 32'd0);
    checkOutput("rstValid3",  {31'h0, valid3}, 32'd0);
    #10;
    rst_n = 1'b1;

    // Single shot, DWELL=0, word held until ready rises.
    expQ.push_back(8'hA6);
    applyStimulus(1'b0, 8'hA6, 1'b0);
    repeat (7) tick;
    checkOutput("shotValidEarly", {31'h0, valid0}, 32'd0);
    checkOutput("shotBusyEarly",  {31'h0, busy0}, 32'd1);
    checkOutput("shotSel7",       {29'h0, sel0}, 32'd7);
    tick;
    checkOutput("shotValid", {31'h0, valid0}, 32'd1);
    checkOutput("shotData",  {24'h0, data0}, 32'hA6);
    checkOutput("shotBusy",  {31'h0, busy0}, 32'd0);
    checkOutput("shotSel",   {29'h0, sel0}, 32'd0);
    ready0 = 1'b1;
    tick;
    checkOutput("shotCleared", {31'h0, valid0}, 32'd0);
    checkOutput("shotHold",    {24'h0, data0}, 32'hA6);

    // DWELL=3: each select value lasts four cycles, word after 32 cycles.
    applyStimulus(1'b1, 8'h3C, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      tick;
      if (k < 32) checkOutput("dwellSel", {29'h0, sel3}, k / 4);
      checkOutput("dwellValid", {31'h0, valid3}, (k == 32) ? 32'd1 : 32'd0);
    end
    checkOutput("dwellData", {24'h0, data3}, 32'h3C);
    checkOutput("dwellBusy", {31'h0, busy3}, 32'd0);

    // Continuous with ready high, inputs swapped between words, stop during
    // the second word.
    expQ.push_back(8'h55);
    applyStimulus(1'b0, 8'h55, 1'b1);
    repeat (8) tick;
    checkOutput("contValid1", {31'h0, valid0}, 32'd1);
    checkOutput("contData1",  {24'h0, data0}, 32'h55);
    checkOutput("contBusy1",  {31'h0, busy0}, 32'd1);
    in0 = 8'hAA;
    expQ.push_back(8'hAA);
    tick;
    checkOutput("contAccepted", {31'h0, valid0}, 32'd0);
    checkOutput("contSel1",     {29'h0, sel0}, 32'd1);
    tick;
    stop0 = 1'b1;
    tick;
    stop0 = 1'b0;
    repeat (4) tick;
    checkOutput("stopStillBusy", {31'h0, busy0}, 32'd1);
    tick;
    checkOutput("contValid2", {31'h0, valid0}, 32'd1);
    checkOutput("contData2",  {24'h0, data0}, 32'hAA);
    checkOutput("stopBusy",   {31'h0, busy0}, 32'd0);
    checkOutput("contOverrun", {31'h0, ovr0}, 32'd0);
    tick;

    // Continuous with ready low: second word dropped, overrun set.
    ready0 = 1'b0;
    expQ.push_back(8'h0F);
    applyStimulus(1'b0, 8'h0F, 1'b1);
    repeat (8) tick;
    checkOutput("ovrValid1", {31'h0, valid0}, 32'd1);
    checkOutput("ovrData1",  {24'h0, data0}, 32'h0F);
    stop0 = 1'b1;
    tick;
    stop0 = 1'b0;
    repeat (6) tick;
    checkOutput("ovrNotYet", {31'h0, ovr0}, 32'd0);
    tick;
    checkOutput("ovrSet",   {31'h0, ovr0}, 32'd1);
    checkOutput("ovrHold",  {24'h0, data0}, 32'h0F);
    checkOutput("ovrValid", {31'h0, valid0}, 32'd1);
    checkOutput("ovrBusy",  {31'h0, busy0}, 32'd0);
    ready0 = 1'b1;
    expQ.push_back(8'h81);
    applyStimulus(1'b0, 8'h81, 1'b0);
    checkOutput("ovrCleared", {31'h0, ovr0}, 32'd0);
    checkOutput("ovrDrained", {31'h0, valid0}, 32'd0);
    repeat (8) tick;
    checkOutput("reValid", {31'h0, valid0}, 32'd1);
    checkOutput("reData",  {24'h0, data0}, 32'h81);
    tick;

    // Asynchronous reset at sel=5, then a clean scan.
    applyStimulus(1'b0, 8'hC3, 1'b0);
    repeat (5) tick;
    checkOutput("midSel", {29'h0, sel0}, 32'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstSel",     {29'h0, sel0}, 32'd0);
    checkOutput("midRstData",    {24'h0, data0}, 32'd0);
    checkOutput("midRstValid",   {31'h0, valid0}, 32'd0);
    checkOutput("midRstBusy",    {31'h0, busy0}, 32'd0);
    checkOutput("midRstOverrun", {31'h0, ovr0}, 32'd0);
    #2;
    rst_n = 1'b1;
    expQ.push_back(8'h5A);
    applyStimulus(1'b0, 8'h5A, 1'b0);
    repeat (8) tick;
    checkOutput("postValid", {31'h0, valid0}, 32'd1);
    checkOutput("postData",  {24'h0, data0}, 32'h5A);
    repeat (2) tick;

    checkOutput("sbDrain", expQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Upstream control stage for the 8:1 combinational multiplexer: drives its three select lines through channels 0..7, samples the mux output once per channel, and packs the eight samples into a byte. The byte goes to downstream logic over a valid/ready handshake. It turns eight slow single-bit inputs behind the mux into a parallel word stream, in single-shot or continuous mode.

## Interface
- DWELL, default 0: extra settle cycles per channel before sampling (0..15).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a scan when idle.
- continuous  in  1  sampled at start and at each word completion. 1 = rescan immediately.
- stop  in  1  pulse; ends continuous mode after the current word completes.
- sel  out  3  registered mux select {s2,s1,s0}; s0 = sel[0].
- mux_y  in  1  combinational mux output for the current sel.
- data  out  8  captured word; bit k = sample taken with sel==k.
- valid  out  1  data holds an unaccepted word.
- ready  in  1  downstream accepts data when valid&&ready.
- busy  out  1  high in SCAN state.
- overrun  out  1  sticky; set when a completed word is dropped. Cleared only by reset or start.

## Operation
- States: IDLE, SCAN.
- IDLE -> SCAN on start. start is ignored in SCAN. Start clears overrun and the shift register, and latches continuous.
- In SCAN, the block holds a 4-bit dwell counter and a 3-bit channel index driven onto sel.
  - Each channel lasts DWELL+1 cycles.
  - On the last cycle of a channel, mux_y is captured into shift bit sel, then sel increments (wrapping 7 -> 0) and the dwell counter reloads.
- Completion:
  - The sample with sel==7 completes the word.
  - If valid==0, or valid&&ready in the same cycle, the word loads into data and valid=1.
  - Otherwise the word is dropped, data is unchanged, and overrun is set.
- After completion:
  - If continuous is latched and no stop is pending, stay in SCAN with sel=0.
  - Else go to IDLE.
  - A stop pulse during SCAN is remembered until completion. stop in IDLE has no effect.
- valid clears on valid&&ready when no new word loads in the same cycle. Load has priority over clear.
- data holds its value while valid==0 after acceptance. It is not zeroed.

## Timing
- Reset values:
  - state=IDLE, sel=0, data=8'h00, valid=0, busy=0, overrun=0.
  - Dwell counter=0, shift register=0, stop-pending=0.
- sel is 0 in IDLE and changes only on clock edges. mux_y must be stable within the cycle following a sel change.
- Latency from the start edge to valid=1 is exactly 8*(DWELL+1) cycles. With DWELL=0, valid rises on the 8th edge after the start edge.
- Continuous throughput is one word per 8*(DWELL+1) cycles, with no gap between words.
- Async reset mid-scan: all state returns to reset values immediately, and the partial word is discarded.
- A simultaneous completion and ready with valid=1 accepts the old word and loads the new one. No overrun, and valid stays 1.

## Structure
- Shared package mux_scan_pkg holds:
  - scan_state_t enum {IDLE, SCAN}.
  - NUM_CH=8 and SEL_W=3.
  - DWELL_W=4.
- Single module, with no sub-module. The dwell counter is inline; the design is small enough not to warrant a separate timer.
- The module instantiates nothing. The top level wires sel to the mux selects and the mux y to mux_y.

## Test plan
- DWELL=0, single shot, mux inputs i7..i0=8'b1010_0110 -> valid on the 8th edge after start, data=8'hA6, busy falls the same edge, sel=0.
- DWELL=3, inputs 8'h3C -> sel holds each value 4 cycles, valid after 32 cycles, data=8'h3C.
- Continuous with ready=1 constantly, inputs changed between words to 8'h55 then 8'hAA -> consecutive words 8'h55, 8'hAA every 8 cycles, overrun=0.
- Continuous with ready=0 -> first word 8'h0F held; second completion sets overrun=1, data stays 8'h0F; the next start clears overrun.
- stop pulse at cycle 3 of a continuous scan -> that word completes with valid=1, state returns to IDLE, busy=0.
- rst_n asserted at sel=5 mid-scan -> outputs immediately return to reset values. A fresh start then produces a full correct word.
